// File: rtl/page_mapper_pkg.sv
// rtl/page_mapper_pkg.sv - page port command codes and default bank assignments
package page_mapper_pkg;

    localparam logic [2:0] PAGE_CMD_RAM     = 3'd0;
    localparam logic [2:0] PAGE_CMD_DISK    = 3'd1;
    localparam logic [2:0] PAGE_CMD_ROM     = 3'd2;
    localparam logic [2:0] PAGE_CMD_ROM_ALT = 3'd3;
    localparam logic [2:0] PAGE_CMD_WIDX    = 3'd4;
    localparam logic [2:0] PAGE_CMD_BANK    = 3'd5;
    localparam logic [2:0] PAGE_CMD_WP      = 3'd6;
    localparam logic [2:0] PAGE_CMD_NOP     = 3'd7;

    localparam int ROM_PAGE_DEF = 1;
    localparam int PAGE_OFS_DEF = 2;

endpackage

// File: rtl/page_mapper.sv
// rtl/page_mapper.sv - windowed bank mapper with legacy page port, readback and ROM auto-exit
module page_mapper
    import page_mapper_pkg::*;
#(
    parameter int PAGE_BITS = 4,
    parameter int WINDOWS   = 1,
    parameter int ADDR_W    = 25,
    parameter int ROM_PAGE  = ROM_PAGE_DEF,
    parameter int PAGE_OFS  = PAGE_OFS_DEF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           cpu_dout,
    input  logic                 cpu_wr_n,
    input  logic                 cpu_rd,
    input  logic                 port_sel,
    input  logic                 exit_en,
    input  logic                 bypass,
    input  logic                 load_page0,
    output logic [7:0]           dout,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [PAGE_BITS-1:0] cur_bank,
    output logic                 romp,
    output logic                 we_ok
);

    localparam int WIN_W = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;
    localparam logic [PAGE_BITS-1:0] ROM_BANK = PAGE_BITS'(ROM_PAGE);

    logic [PAGE_BITS-1:0] bank [WINDOWS];
    logic [WINDOWS-1:0]   wp;
    logic [WIN_W-1:0]     widx;
    logic                 old_wr;

    logic [WIN_W-1:0]     win;
    logic [WIN_W-1:0]     sel;
    logic [PAGE_BITS-1:0] disk_bank;
    logic                 wr_event;
    logic                 auto_exit;

    // A single window means every access and every widx lands on bank 0
    assign win = (WINDOWS == 1) ? '0 : cpu_addr[15 -: WIN_W];
    assign sel = (WINDOWS == 1) ? '0 : widx;

    assign disk_bank = PAGE_BITS'(PAGE_OFS + int'(cpu_dout[PAGE_BITS-1:0]));
    assign wr_event  = old_wr & ~cpu_wr_n & port_sel;
    assign auto_exit = exit_en & cpu_addr[15] & (cpu_rd | ~cpu_wr_n) & ~port_sel;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < WINDOWS; i++) bank[i] <= ROM_BANK;
            wp     <= '0;
            widx   <= '0;
            old_wr <= 1'b1;
        end else if (load_page0) begin
            for (int i = 0; i < WINDOWS; i++) bank[i] <= '0;
            wp     <= '0;
            old_wr <= 1'b1;
        end else begin
            old_wr <= cpu_wr_n;
            if (wr_event) begin
                case (cpu_addr[2:0])
                    PAGE_CMD_RAM:
                        for (int i = 0; i < WINDOWS; i++) bank[i] <= '0;
                    PAGE_CMD_DISK:
                        for (int i = 0; i < WINDOWS; i++) bank[i] <= disk_bank;
                    PAGE_CMD_ROM, PAGE_CMD_ROM_ALT:
                        for (int i = 0; i < WINDOWS; i++) bank[i] <= ROM_BANK;
                    PAGE_CMD_WIDX: widx      <= cpu_dout[WIN_W-1:0];
                    PAGE_CMD_BANK: bank[sel] <= cpu_dout[PAGE_BITS-1:0];
                    PAGE_CMD_WP:   wp        <= cpu_dout[WINDOWS-1:0];
                    default: ;
                endcase
            end else if (auto_exit) begin
                for (int i = 0; i < WINDOWS; i++) bank[i] <= '0;
            end
        end
    end

    always_comb begin
        dout = 8'hFF;
        case (cpu_addr[2:0])
            PAGE_CMD_WIDX: dout = 8'(widx);
            PAGE_CMD_BANK: dout = 8'(bank[sel]);
            PAGE_CMD_WP:   dout = 8'(wp);
            default:       dout = 8'hFF;
        endcase
    end

    assign cur_bank = bank[win];
    assign romp     = (cur_bank == ROM_BANK);
    assign ram_addr = bypass ? ADDR_W'(cpu_addr) : ADDR_W'({cur_bank, cpu_addr});
    assign we_ok    = ~cpu_wr_n & ~wp[win] & ~romp & ~port_sel;

endmodule

// File: tb/tb_page_mapper.sv
// tb/tb_page_mapper.sv - scoreboard bench for page_mapper with four windows
module tb_page_mapper;

    localparam int PAGE_BITS = 4;
    localparam int WINDOWS   = 4;
    localparam int ADDR_W    = 25;

    logic                 clk_sys = 1'b0;
    logic                 reset = 1'b1;
    logic [15:0]          cpu_addr = '0;
    logic [7:0]           cpu_dout = '0;
    logic                 cpu_wr_n = 1'b1;
    logic                 cpu_rd = 1'b0;
    logic                 port_sel = 1'b0;
    logic                 exit_en = 1'b0;
    logic                 bypass = 1'b0;
    logic                 load_page0 = 1'b0;
    logic [7:0]           dout;
    logic [ADDR_W-1:0]    ram_addr;
    logic [PAGE_BITS-1:0] cur_bank;
    logic                 romp;
    logic                 we_ok;

    page_mapper #(
        .PAGE_BITS(PAGE_BITS),
        .WINDOWS  (WINDOWS),
        .ADDR_W   (ADDR_W),
        .ROM_PAGE (1),
        .PAGE_OFS (2)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_wr_n  (cpu_wr_n),
        .cpu_rd    (cpu_rd),
        .port_sel  (port_sel),
        .exit_en   (exit_en),
        .bypass    (bypass),
        .load_page0(load_page0),
        .dout      (dout),
        .ram_addr  (ram_addr),
        .cur_bank  (cur_bank),
        .romp      (romp),
        .we_ok     (we_ok)
    );

    always #5 clk_sys = ~clk_sys;

    localparam int S_ADDR = 0, S_ROMP = 1, S_WEOK = 2, S_DOUT = 3, S_BANK = 4;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always @(negedge clk_sys) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sig)
                S_ADDR:  act = 32'(ram_addr);
                S_ROMP:  act = 32'(romp);
                S_WEOK:  act = 32'(we_ok);
                S_DOUT:  act = 32'(dout);
                default: act = 32'(cur_bank);
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb.push_back(e);
        @(negedge clk_sys);
        #1;
    endtask

    task automatic port_write(input logic [2:0] a, input logic [7:0] d);
        cpu_addr = 16'hFFF8 | 16'(a);
        cpu_dout = d;
        port_sel = 1'b1;
        cpu_wr_n = 1'b0;
        tick(1);
        cpu_wr_n = 1'b1;
        tick(1);
        port_sel = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;

        cpu_addr = 16'h1234;
        chk("reset_romp", S_ROMP, 32'd1);
        chk("reset_addr", S_ADDR, 32'h0011234);
        chk("reset_bank", S_BANK, 32'd1);
        chk("reset_weok_idle", S_WEOK, 32'd0);
        cpu_addr = 16'hFFFE;
        chk("reset_wp_rd", S_DOUT, 32'h00);
        cpu_addr = 16'hFFFF;
        chk("rd_addr7", S_DOUT, 32'hFF);

        port_write(3'd1, 8'h03);
        cpu_addr = 16'h8000;
        chk("disk_addr", S_ADDR, 32'h0058000);
        chk("disk_romp", S_ROMP, 32'd0);
        cpu_addr = 16'h0000;
        chk("disk_bank_w0", S_BANK, 32'd5);
        bypass = 1'b1;
        cpu_addr = 16'h8000;
        chk("bypass_addr", S_ADDR, 32'h0008000);
        bypass = 1'b0;

        port_write(3'd4, 8'h02);
        port_write(3'd5, 8'h07);
        cpu_addr = 16'h8000;
        chk("win2_addr", S_ADDR, 32'h0078000);
        cpu_addr = 16'h0000;
        chk("win0_bank", S_BANK, 32'd5);
        cpu_addr = 16'h4000;
        chk("win1_bank", S_BANK, 32'd5);
        cpu_addr = 16'hC000;
        chk("win3_bank", S_BANK, 32'd5);
        cpu_addr = 16'hFFFD;
        chk("rd_bank", S_DOUT, 32'h07);
        cpu_addr = 16'hFFFC;
        chk("rd_widx", S_DOUT, 32'h02);

        port_write(3'd6, 8'h04);
        cpu_addr = 16'hFFFE;
        chk("rd_wp", S_DOUT, 32'h04);
        cpu_wr_n = 1'b0;
        cpu_addr = 16'h8000;
        chk("wp_8000", S_WEOK, 32'd0);
        cpu_addr = 16'hBFFF;
        chk("wp_bfff", S_WEOK, 32'd0);
        cpu_addr = 16'h7FFF;
        chk("wp_7fff", S_WEOK, 32'd1);
        cpu_addr = 16'hC000;
        chk("wp_c000", S_WEOK, 32'd1);
        cpu_addr = 16'h0000;
        chk("wp_0000", S_WEOK, 32'd1);
        cpu_wr_n = 1'b1;
        tick(1);

        port_write(3'd2, 8'h00);
        cpu_addr = 16'h0000;
        chk("rom_romp", S_ROMP, 32'd1);
        cpu_wr_n = 1'b0;
        chk("rom_weok", S_WEOK, 32'd0);
        cpu_wr_n = 1'b1;
        cpu_addr = 16'hC000;
        cpu_rd   = 1'b1;
        tick(2);
        cpu_rd = 1'b0;
        chk("noexit_bank", S_BANK, 32'd1);
        exit_en = 1'b1;
        cpu_rd  = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        chk("exit_addr", S_ADDR, 32'h000C000);
        chk("exit_romp", S_ROMP, 32'd0);
        cpu_addr = 16'h4000;
        chk("exit_win1", S_BANK, 32'd0);
        exit_en = 1'b0;

        port_write(3'd1, 8'h0F);
        cpu_addr = 16'h0000;
        chk("disk_wrap", S_BANK, 32'd1);

        // Long low strobe: switching to command 1 mid-pulse must not re-trigger
        cpu_addr = 16'hFFF8;
        cpu_dout = 8'h00;
        port_sel = 1'b1;
        cpu_wr_n = 1'b0;
        tick(1);
        cpu_addr = 16'hFFF9;
        cpu_dout = 8'h03;
        tick(23);
        chk("long_wr_once", S_BANK, 32'd0);
        cpu_wr_n = 1'b1;
        tick(1);
        port_sel = 1'b0;

        reset    = 1'b1;
        cpu_addr = 16'hFFF9;
        cpu_dout = 8'h03;
        port_sel = 1'b1;
        cpu_wr_n = 1'b0;
        tick(3);
        reset    = 1'b0;
        cpu_wr_n = 1'b1;
        tick(1);
        port_sel = 1'b0;
        cpu_addr = 16'h0000;
        chk("rst_overlap_bank", S_BANK, 32'd1);
        chk("rst_overlap_romp", S_ROMP, 32'd1);

        port_write(3'd6, 8'h0F);
        port_write(3'd4, 8'h03);
        load_page0 = 1'b1;
        cpu_addr   = 16'hFFFA;
        port_sel   = 1'b1;
        cpu_wr_n   = 1'b0;
        tick(2);
        load_page0 = 1'b0;
        cpu_wr_n   = 1'b1;
        tick(1);
        port_sel = 1'b0;
        cpu_addr = 16'h0000;
        chk("ld0_romp", S_ROMP, 32'd0);
        chk("ld0_bank", S_BANK, 32'd0);
        cpu_addr = 16'hFFFE;
        chk("ld0_wp", S_DOUT, 32'h00);
        cpu_addr = 16'hFFFC;
        chk("ld0_widx_kept", S_DOUT, 32'h03);
        cpu_addr = 16'h0000;
        cpu_wr_n = 1'b0;
        chk("ld0_weok", S_WEOK, 32'd1);
        cpu_wr_n = 1'b1;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_sys);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
